// File: rtl/time_cnt_gen_if.sv
// Control and display bus of the min:sec:sub timer.
// The key FSM drives the master side and the timer is the slave.
interface time_cnt_gen_if #(
   parameter int FIELD_W = 8
);
   logic                   run;
   logic                   dir;
   logic                   clear;
   logic                   load;
   logic [3*FIELD_W-1:0]   load_val;
   logic                   lap;
   logic [FIELD_W-1:0]     min;
   logic [FIELD_W-1:0]     sec;
   logic [FIELD_W-1:0]     sub;
   logic                   tick;
   logic                   wrap;
   logic                   expired;
   logic [FIELD_W-1:0]     lap_min;
   logic [FIELD_W-1:0]     lap_sec;
   logic [FIELD_W-1:0]     lap_sub;
   logic                   lap_valid;

   modport master (
      output run, dir, clear, load, load_val, lap,
      input  min, sec, sub, tick, wrap, expired,
             lap_min, lap_sec, lap_sub, lap_valid
   );

   modport slave (
      input  run, dir, clear, load, load_val, lap,
      output min, sec, sub, tick, wrap, expired,
             lap_min, lap_sec, lap_sub, lap_valid
   );
endinterface

// File: rtl/time_cnt_gen.sv
// Up/down min:sec:sub timer with prescaler, clamped load and countdown expiry.
// Define TIMER_LAP_EN to build the lap-capture registers.
module time_cnt_gen #(
   parameter int TICK_DIV = 5_000_000,
   parameter int FIELD_W  = 8,
   parameter int MIN_MAX  = 59,
   parameter int SEC_MAX  = 59,
   parameter int SUB_MAX  = 9
) (
   input logic           sclk,
   input logic           nrst,
   time_cnt_gen_if.slave bus
);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [FIELD_W-1:0] MIN_L = FIELD_W'(MIN_MAX);
   localparam logic [FIELD_W-1:0] SEC_L = FIELD_W'(SEC_MAX);
   localparam logic [FIELD_W-1:0] SUB_L = FIELD_W'(SUB_MAX);
   localparam logic [FIELD_W-1:0] ZERO  = '0;

   logic [PW-1:0]      presc_q, presc_d;
   logic [FIELD_W-1:0] min_q, min_d, sec_q, sec_d, sub_q, sub_d;
   logic               tick_q, tick_d, wrap_q, wrap_d, expired_q, expired_d;
   logic               tick_edge, at_zero;

   function automatic logic [FIELD_W-1:0] clamp(input logic [FIELD_W-1:0] v,
                                                input logic [FIELD_W-1:0] mx);
      return (v > mx) ? mx : v;
   endfunction

   assign tick_edge = bus.run && (presc_q == PW'(TICK_DIV - 1));
   assign at_zero   = (min_q == ZERO) && (sec_q == ZERO) && (sub_q == ZERO);

   // Next-state: clear beats load beats tick; a down tick at zero leaves fields alone.
   always_comb begin
      presc_d   = presc_q;
      min_d     = min_q;
      sec_d     = sec_q;
      sub_d     = sub_q;
      tick_d    = 1'b0;
      wrap_d    = 1'b0;
      expired_d = expired_q;
      if (bus.clear) begin
         presc_d   = '0;
         min_d     = '0;
         sec_d     = '0;
         sub_d     = '0;
         expired_d = 1'b0;
      end else if (bus.load) begin
         presc_d   = '0;
         min_d     = clamp(bus.load_val[3*FIELD_W-1:2*FIELD_W], MIN_L);
         sec_d     = clamp(bus.load_val[2*FIELD_W-1:FIELD_W], SEC_L);
         sub_d     = clamp(bus.load_val[FIELD_W-1:0], SUB_L);
         expired_d = 1'b0;
      end else if (tick_edge) begin
         presc_d = '0;
         tick_d  = 1'b1;
         if (!bus.dir) begin
            if (sub_q == SUB_L) begin
               sub_d = '0;
               if (sec_q == SEC_L) begin
                  sec_d = '0;
                  if (min_q == MIN_L) begin
                     min_d  = '0;
                     wrap_d = 1'b1;
                  end else begin
                     min_d = min_q + 1'b1;
                  end
               end else begin
                  sec_d = sec_q + 1'b1;
               end
            end else begin
               sub_d = sub_q + 1'b1;
            end
         end else if (!at_zero) begin
            if (sub_q == ZERO) begin
               sub_d = SUB_L;
               if (sec_q == ZERO) begin
                  sec_d = SEC_L;
                  min_d = min_q - 1'b1;
               end else begin
                  sec_d = sec_q - 1'b1;
               end
            end else begin
               sub_d = sub_q - 1'b1;
            end
            if ((min_q == ZERO) && (sec_q == ZERO) && (sub_q == FIELD_W'(1)))
               expired_d = 1'b1;
         end
      end else if (bus.run) begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         presc_q   <= '0;
         min_q     <= '0;
         sec_q     <= '0;
         sub_q     <= '0;
         tick_q    <= 1'b0;
         wrap_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         min_q     <= min_d;
         sec_q     <= sec_d;
         sub_q     <= sub_d;
         tick_q    <= tick_d;
         wrap_q    <= wrap_d;
         expired_q <= expired_d;
      end
   end

   assign bus.min     = min_q;
   assign bus.sec     = sec_q;
   assign bus.sub     = sub_q;
   assign bus.tick    = tick_q;
   assign bus.wrap    = wrap_q;
   assign bus.expired = expired_q;

`ifdef TIMER_LAP_EN
   logic [FIELD_W-1:0] lap_min_q, lap_sec_q, lap_sub_q;
   logic               lap_valid_q;

   // Lap samples the pre-edge fields; clear or load in the same cycle suppresses it.
   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         lap_min_q   <= '0;
         lap_sec_q   <= '0;
         lap_sub_q   <= '0;
         lap_valid_q <= 1'b0;
      end else if (bus.clear) begin
         lap_min_q   <= '0;
         lap_sec_q   <= '0;
         lap_sub_q   <= '0;
         lap_valid_q <= 1'b0;
      end else if (bus.lap && !bus.load) begin
         lap_min_q   <= min_q;
         lap_sec_q   <= sec_q;
         lap_sub_q   <= sub_q;
         lap_valid_q <= 1'b1;
      end
   end

   assign bus.lap_min   = lap_min_q;
   assign bus.lap_sec   = lap_sec_q;
   assign bus.lap_sub   = lap_sub_q;
   assign bus.lap_valid = lap_valid_q;
`else
   // Lap is ignored; masking it keeps the input consumed while the output stays 0.
   assign bus.lap_min   = '0;
   assign bus.lap_sec   = '0;
   assign bus.lap_sub   = '0;
   assign bus.lap_valid = bus.lap & 1'b0;
`endif
endmodule

// File: tb/tb_time_cnt_gen.sv
// Self-checking bench for time_cnt_gen: directed steps then random traffic
// against a model that keeps the time as a single count of sub-second ticks.
module tb_time_cnt_gen;
   localparam int TICK_DIV = 4;
   localparam int FIELD_W  = 8;
   localparam int MIN_MAX  = 59;
   localparam int SEC_MAX  = 59;
   localparam int SUB_MAX  = 9;
   localparam int SUB_N    = SUB_MAX + 1;
   localparam int SEC_N    = SEC_MAX + 1;
   localparam int TOTAL    = (MIN_MAX + 1) * SEC_N * SUB_N;

   logic sclk = 1'b0;
   logic nrst = 1'b0;

   time_cnt_gen_if #(.FIELD_W(FIELD_W)) bus ();

   time_cnt_gen #(
      .TICK_DIV (TICK_DIV),
      .FIELD_W  (FIELD_W),
      .MIN_MAX  (MIN_MAX),
      .SEC_MAX  (SEC_MAX),
      .SUB_MAX  (SUB_MAX)
   ) dut (
      .sclk (sclk),
      .nrst (nrst),
      .bus  (bus)
   );

   always #5 sclk = ~sclk;

   int errors = 0;
   int checks = 0;

   int m_t, m_p, m_lap_t;
   bit m_tick, m_wrap, m_exp, m_lap_v;

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      assert (obs === 32'(exp)) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clampi(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic int to_total(input logic [3*FIELD_W-1:0] v);
      int mn, sc, sb;
      mn = clampi(int'(v[23:16]), MIN_MAX);
      sc = clampi(int'(v[15:8]), SEC_MAX);
      sb = clampi(int'(v[7:0]), SUB_MAX);
      return (mn * SEC_N + sc) * SUB_N + sb;
   endfunction

   task automatic model_reset();
      m_t = 0; m_p = 0; m_lap_t = 0;
      m_tick = 0; m_wrap = 0; m_exp = 0; m_lap_v = 0;
   endtask

   // Applies one clock edge of the timer rules to the tick-count model.
   task automatic model_edge();
      m_tick = 0;
      m_wrap = 0;
      if (bus.clear) begin
         m_t = 0; m_p = 0; m_exp = 0; m_lap_t = 0; m_lap_v = 0;
      end else if (bus.load) begin
         m_t = to_total(bus.load_val); m_p = 0; m_exp = 0;
      end else begin
         if (bus.lap) begin
            m_lap_t = m_t; m_lap_v = 1;
         end
         if (bus.run) begin
            if (m_p == TICK_DIV - 1) begin
               m_p = 0;
               m_tick = 1;
               if (!bus.dir) begin
                  if (m_t == TOTAL - 1) begin
                     m_t = 0; m_wrap = 1;
                  end else begin
                     m_t = m_t + 1;
                  end
               end else if (m_t > 0) begin
                  m_t = m_t - 1;
                  if (m_t == 0) m_exp = 1;
               end
            end else begin
               m_p = m_p + 1;
            end
         end
      end
   endtask

   task automatic check_output();
      int lt;
      bit lv;
`ifdef TIMER_LAP_EN
      lt = m_lap_t; lv = m_lap_v;
`else
      lt = 0; lv = 0;
`endif
      check("min",       32'(bus.min),       m_t / (SUB_N * SEC_N));
      check("sec",       32'(bus.sec),       (m_t / SUB_N) % SEC_N);
      check("sub",       32'(bus.sub),       m_t % SUB_N);
      check("tick",      32'(bus.tick),      int'(m_tick));
      check("wrap",      32'(bus.wrap),      int'(m_wrap));
      check("expired",   32'(bus.expired),   int'(m_exp));
      check("lap_min",   32'(bus.lap_min),   lt / (SUB_N * SEC_N));
      check("lap_sec",   32'(bus.lap_sec),   (lt / SUB_N) % SEC_N);
      check("lap_sub",   32'(bus.lap_sub),   lt % SUB_N);
      check("lap_valid", 32'(bus.lap_valid), int'(lv));
   endtask

   task automatic step();
      @(posedge sclk);
      model_edge();
      #1;
      check_output();
   endtask

   task automatic apply_stimulus(input bit c, input bit l, input bit lp,
                                 input logic [3*FIELD_W-1:0] v);
      bus.clear = c; bus.load = l; bus.lap = lp; bus.load_val = v;
      step();
      bus.clear = 0; bus.load = 0; bus.lap = 0;
   endtask

   task automatic run_cycles(input int n);
      repeat (n) step();
   endtask

   initial begin
      int ticks, last, wraps;
      logic [3*FIELD_W-1:0] v;
      bus.run = 0; bus.dir = 0; bus.clear = 0; bus.load = 0; bus.lap = 0;
      bus.load_val = '0;
      model_reset();
      #12;
      $display("[TB] reset state");
      check_output();
      nrst = 1'b1;

      $display("[TB] up count from reset");
      bus.run = 1;
      ticks = 0; last = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (bus.tick) begin
            if (last >= 0) check("tick_gap", 32'(i - last), TICK_DIV);
            last = i;
            ticks++;
         end
      end
      check("tick_count", 32'(ticks), 10);
      check("sec_after40", 32'(bus.sec), 1);
      check("sub_after40", 32'(bus.sub), 0);

      $display("[TB] up wrap");
      apply_stimulus(0, 1, 0, {8'd59, 8'd59, 8'd8});
      wraps = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.wrap) wraps++;
      end
      check("wrap_count", 32'(wraps), 1);

      $display("[TB] down to expiry");
      bus.dir = 1;
      apply_stimulus(0, 1, 0, {8'd0, 8'd0, 8'd2});
      run_cycles(16);
      check("expired_hold", 32'(bus.expired), 1);
      check("sub_hold", 32'(bus.sub), 0);
      apply_stimulus(0, 1, 0, {8'd0, 8'd1, 8'd0});
      check("expired_cleared", 32'(bus.expired), 0);

      $display("[TB] clamped load and hold");
      bus.dir = 0; bus.run = 0;
      apply_stimulus(0, 1, 0, {8'd75, 8'd99, 8'd15});
      check("clamp_min", 32'(bus.min), 59);
      check("clamp_sec", 32'(bus.sec), 59);
      check("clamp_sub", 32'(bus.sub), 9);
      bus.run = 1; run_cycles(2);
      bus.run = 0; run_cycles(20);
      bus.run = 1; run_cycles(2);
      check("tick_after_hold", 32'(bus.tick), 1);

      $display("[TB] command priority");
      apply_stimulus(1, 0, 0, '0);
      run_cycles(3);
      apply_stimulus(1, 1, 0, {8'd12, 8'd34, 8'd5});
      check("clr_ld_tick_sub", 32'(bus.sub), 0);
      check("clr_ld_tick_min", 32'(bus.min), 0);
      run_cycles(3);
      apply_stimulus(0, 1, 0, {8'd12, 8'd34, 8'd5});
      check("ld_tick_min", 32'(bus.min), 12);
      check("ld_tick_tick", 32'(bus.tick), 0);
      run_cycles(4);
      check("ld_restart_sub", 32'(bus.sub), 6);

      $display("[TB] lap capture");
      apply_stimulus(0, 1, 0, {8'd0, 8'd3, 8'd4});
      run_cycles(3);
      apply_stimulus(0, 0, 1, '0);
      check("lap_tick_sub", 32'(bus.sub), 5);
`ifdef TIMER_LAP_EN
      check("lap_cap_sub", 32'(bus.lap_sub), 4);
      check("lap_cap_sec", 32'(bus.lap_sec), 3);
      check("lap_cap_valid", 32'(bus.lap_valid), 1);
`endif
      apply_stimulus(0, 1, 1, {8'd1, 8'd2, 8'd3});
      run_cycles(2);
      apply_stimulus(1, 0, 1, '0);
      check("lap_valid_clear", 32'(bus.lap_valid), 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         int r;
         bit c, l, lp;
         bus.run = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) bus.dir = ~bus.dir;
         r  = $urandom_range(0, 99);
         c  = (r < 2);
         l  = (r >= 2) && (r < 8);
         lp = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 2))
            0:       v = {8'd0, 8'd0, 8'($urandom_range(0, 12))};
            1:       v = {8'd59, 8'd59, 8'($urandom_range(5, 12))};
            default: v = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255))};
         endcase
         apply_stimulus(c, l, lp, v);
      end

      $display("[TB] asynchronous reset");
      bus.run = 1; bus.dir = 0;
      apply_stimulus(0, 1, 1, {8'd7, 8'd8, 8'd9});
      run_cycles(2);
      #3;
      nrst = 1'b0;
      #1;
      model_reset();
      check_output();
      #1;
      nrst = 1'b1;
      run_cycles(9);
      check("post_reset_sub", 32'(bus.sub), 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
